mac_byte_serializer: RTL and testbench

Output stage placed directly downstream of the MAC accumulator. It buffers complete WIDTH-bit accumulation results in a small FIFO and streams each result MSB-first as 8-bit beats over a valid/ready handshake. The full accumulator value can then leave the chip over the 8-bit dedicated output bus, instead of only its top byte. An optional trailing XOR checksum byte is available per word.

---
 rtl/mac_byte_serializer.sv | 168 ++++++++++++++++
 tb/tb_mac_byte_serializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mac_byte_serializer.sv
// mac_byte_serializer: buffers WIDTH-bit MAC results in a DEPTH-entry FIFO and
// streams each word MSB-first as 8-bit beats over a valid/ready handshake.
// Optional build macro MAC_SER_CKSUM_EN appends an XOR checksum beat per word.
module mac_byte_serializer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             ovf
);

    localparam int NB = WIDTH / 8;
`ifdef MAC_SER_CKSUM_EN
    localparam int NBEATS = NB + 1;
`else
    localparam int NBEATS = NB;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(NBEATS);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBEATS - 1);
`ifdef MAC_SER_CKSUM_EN
    localparam logic [IW-1:0] CK_IDX   = IW'(NB);
`endif

    typedef enum logic {IDLE, SEND} state_t;

    // FIFO storage and pointers; count carries one extra bit for full vs empty
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             fifo_empty, push, pop;

    // Serializer state
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q;
    logic [IW-1:0]    idx_q, idx_nxt;
    logic             vld_q, last_q;
    logic [7:0]       data_q;
    logic             load, adv, go_idle, xfer, last_beat;
`ifdef MAC_SER_CKSUM_EN
    logic [7:0]       csum_q;

    function automatic logic [7:0] xor_bytes(input logic [WIDTH-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < NB; i++) x ^= w[i*8 +: 8];
        return x;
    endfunction
`endif

    // in_ready depends only on the FIFO fill level, never on the consumer side
    assign fifo_empty = (count == '0);
    assign in_ready   = ena & (count < FULL_CNT);
    assign push       = in_valid & in_ready;
    assign pop        = load;
    assign out_valid  = vld_q & ena;
    assign out_data   = data_q;
    assign out_last   = last_q;
    assign xfer       = out_valid & out_ready;
    assign last_beat  = (idx_q == LAST_IDX);
    assign idx_nxt    = idx_q + 1'b1;

    // FIFO data write (storage needs no reset)
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (in_valid & ~in_ready & ena) ovf <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and datapath control; loads chain on the last beat to avoid bubbles
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        go_idle = 1'b0;
        case (state_q)
            IDLE: begin
                if (ena & ~fifo_empty) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (!last_beat) begin
                        adv = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        go_idle = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, beat index and registered output beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q   <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
`ifdef MAC_SER_CKSUM_EN
            csum_q <= '0;
`endif
        end else if (load) begin
            sh_q   <= mem[rptr];
            idx_q  <= '0;
            vld_q  <= 1'b1;
            last_q <= 1'b0;
            data_q <= mem[rptr][WIDTH-1 -: 8];
`ifdef MAC_SER_CKSUM_EN
            csum_q <= xor_bytes(mem[rptr]);
`endif
        end else if (adv) begin
            sh_q   <= sh_q << 8;
            idx_q  <= idx_nxt;
            last_q <= (idx_nxt == LAST_IDX);
`ifdef MAC_SER_CKSUM_EN
            data_q <= (idx_nxt == CK_IDX) ? csum_q : sh_q[WIDTH-9 -: 8];
`else
            data_q <= sh_q[WIDTH-9 -: 8];
`endif
        end else if (go_idle) begin
            idx_q  <= '0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_byte_serializer.sv
// Scoreboard bench for mac_byte_serializer (WIDTH=32, DEPTH=2).
module tb_mac_byte_serializer;

    logic        clk = 1'b0;
    logic        rst, ena, in_valid, in_ready, out_valid, out_last, out_ready, ovf;
    logic [31:0] in_data;
    logic [7:0]  out_data;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    int    xlog[$];
    int    checks = 0, errors = 0, beats_seen = 0, cyc = 0;

    mac_byte_serializer #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected beats for a word: bytes MSB first, plus the hand-computed checksum beat if built in
    task automatic exp_word(input logic [31:0] w, input logic [7:0] ck);
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b.data = w[31-8*i -: 8];
`ifdef MAC_SER_CKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == 3);
`endif
            exp_q.push_back(b);
        end
`ifdef MAC_SER_CKSUM_EN
        b.data = ck;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // Monitor: every beat that transfers is checked against the scoreboard head
    always @(negedge clk) begin
        if (!rst && ena && out_valid && out_ready) begin
            beat_t e;
            beats_seen++;
            xlog.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", {24'h0, out_data}, {24'h0, e.data});
                chk("beat_last", {31'h0, out_last}, {31'h0, e.last});
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the next one
    task automatic push(input logic [31:0] w, input logic acc, input logic [7:0] ck);
        in_valid = 1'b1;
        in_data  = w;
        chk("in_ready_at_push", {31'h0, in_ready}, {31'h0, acc});
        if (acc) exp_word(w, ck);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !out_valid) done = 1;
        end
        chk(name, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_beats(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            if (beats_seen >= n) ok = 1;
        end
        chk("wait_beats", {31'h0, ok}, 32'h1);
    endtask

    initial begin
        int gaps;
        rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_out_last",  {31'h0, out_last}, 0);
        chk("rst_out_data",  {24'h0, out_data}, 0);
        chk("rst_ovf",       {31'h0, ovf}, 0);
        chk("rst_in_ready",  {31'h0, in_ready}, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single word with first-beat latency
        push(32'h1234_5678, 1'b1, 8'h08);
        chk("lat_not_yet", {31'h0, out_valid}, 0);
        @(posedge clk); #1;
        chk("lat_valid", {31'h0, out_valid}, 1);
        chk("lat_msb",   {24'h0, out_data}, 32'h12);
        drain("drain_single");

        // Backpressure on 0x34
        out_ready = 1'b0;
        push(32'h1234_5678, 1'b1, 8'h08);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_data",  {24'h0, out_data}, 32'h34);
            chk("bp_valid", {31'h0, out_valid}, 1);
            chk("bp_last",  {31'h0, out_last}, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("drain_bp");

        // Fill: 3 accepted (2 FIFO + shift register), 4th dropped
        out_ready = 1'b0;
        push(32'h0100_0000, 1'b1, 8'h01);
        push(32'h0002_0000, 1'b1, 8'h02);
        push(32'h0000_0003, 1'b1, 8'h03);
        push(32'hDEAD_BEEF, 1'b0, 8'h00);
        chk("ovf_set", {31'h0, ovf}, 1);
        out_ready = 1'b1;
        drain("drain_full");
        chk("ovf_sticky", {31'h0, ovf}, 1);

        // Back-to-back words with no gap
        xlog.delete();
        push(32'hAABB_CCDD, 1'b1, 8'h00);
        push(32'h0102_0304, 1'b1, 8'h04);
        drain("drain_b2b");
        gaps = 0;
        for (int i = 1; i < xlog.size(); i++)
            if (xlog[i] - xlog[i-1] != 1) gaps++;
        chk("b2b_beats", xlog.size(), exp_q.size() + 2 * ((xlog.size() > 8) ? 5 : 4));
        chk("b2b_gaps", gaps, 0);

        // Asynchronous reset mid-word
        beats_seen = 0;
        push(32'hAABB_CCDD, 1'b1, 8'h00);
        wait_beats(2);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mrst_valid", {31'h0, out_valid}, 0);
        chk("mrst_data",  {24'h0, out_data}, 0);
        chk("mrst_last",  {31'h0, out_last}, 0);
        chk("mrst_ovf",   {31'h0, ovf}, 0);
        chk("mrst_ready", {31'h0, in_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push(32'h0102_0304, 1'b1, 8'h04);
        drain("drain_after_rst");

        // ena stall mid-word resumes on the same byte
        beats_seen = 0;
        push(32'hAABB_CCDD, 1'b1, 8'h00);
        wait_beats(2);
        #1 ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'h0, out_valid}, 0);
            chk("stall_ready", {31'h0, in_ready}, 0);
            chk("stall_data",  {24'h0, out_data}, 32'hCC);
        end
        @(posedge clk); #1;
        ena = 1'b1;
        drain("drain_stall");

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
